synaptic_current_accumulator: RTL and testbench

SYNAPTIC_CURRENT_ACCUMULATOR -- requirements
Module: synaptic_current_accumulator

---
 rtl/snn_pkg.sv | 23 ++
 rtl/sat_shift.sv | 38 +++
 rtl/synaptic_current_accumulator.sv | 141 ++++++++++++++
 tb/tb_synaptic_current_accumulator.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath blocks: accumulator FSM
// states and a constant-foldable ceil(log2) used to size counters and sums.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FINISH
    } acc_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_shift.sv
// Combinational arithmetic right shift (floor) followed by signed saturation
// from IW bits down to OW bits; sat_o flags that the clamp was applied.
module sat_shift #(
    parameter int IW    = 16,
    parameter int OW    = 8,
    parameter int SHIFT = 0
) (
    input  logic [IW-1:0] value_i,
    output logic [OW-1:0] result_o,
    output logic          sat_o
);

    // One guard bit above the wider of IW/OW keeps the bound constants positive/negative.
    localparam int CW = ((IW > OW) ? IW : OW) + 1;

    logic signed [IW-1:0] shifted;
    logic signed [CW-1:0] ext;
    logic signed [CW-1:0] maxv;
    logic signed [CW-1:0] minv;

    assign shifted = $signed(value_i) >>> SHIFT;

    always_comb begin
        ext      = {{(CW-IW){shifted[IW-1]}}, shifted};
        maxv     = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
        minv     = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};
        result_o = ext[OW-1:0];
        sat_o    = 1'b0;
        if (ext > maxv) begin
            result_o = maxv[OW-1:0];
            sat_o    = 1'b1;
        end else if (ext < minv) begin
            result_o = minv[OW-1:0];
            sat_o    = 1'b1;
        end
    end

endmodule

// File: rtl/synaptic_current_accumulator.sv
// Multi-cycle weighted spike sum: snapshots spikes/weights on start, adds P
// gated weights per beat, then shifts/saturates the total into input_current.
module synaptic_current_accumulator
    import snn_pkg::*;
#(
    parameter int M     = 24,
    parameter int W     = 8,
    parameter int P     = 4,
    parameter int OW    = 8,
    parameter int SHIFT = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [M-1:0]    input_spikes,
    input  logic [M*W-1:0]  weights,
    output logic            busy,
    output logic            done,
    output logic [OW-1:0]   input_current,
    output logic            saturated
);

    localparam int B   = (M + P - 1) / P;
    localparam int NP  = B * P;
    localparam int AW  = W + int'(clog2(M)) + 1;
    localparam int BCW = int'(clog2(B + 1));

    acc_state_t         state_q, state_d;
    logic [M-1:0]       spk_q, spk_d;
    logic [M*W-1:0]     wts_q, wts_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [BCW-1:0]     beat_q, beat_d;
    logic [OW-1:0]      cur_q, cur_d;
    logic               sat_q, sat_d;
    logic               done_q, done_d;

    // Zero padding makes the lanes past M in the last beat contribute nothing.
    logic [NP-1:0]      spk_pad;
    logic [NP*W-1:0]    wts_pad;
    logic [P-1:0]       lane_spk;
    logic [P-1:0][W-1:0] lane_w;
    logic [AW-1:0]      beat_sum;
    logic [OW-1:0]      fin_cur;
    logic               fin_sat;

    assign spk_pad = NP'(spk_q);
    assign wts_pad = (NP*W)'(wts_q);

    sat_shift #(
        .IW    (AW),
        .OW    (OW),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .value_i  (acc_q),
        .result_o (fin_cur),
        .sat_o    (fin_sat)
    );

    always_comb begin
        lane_spk = '0;
        lane_w   = '0;
        for (int unsigned b = 0; b < B; b++) begin
            if (beat_q == BCW'(b)) begin
                for (int unsigned j = 0; j < P; j++) begin
                    lane_spk[j] = spk_pad[b*P + j];
                    lane_w[j]   = wts_pad[(b*P + j)*W +: W];
                end
            end
        end
        beat_sum = '0;
        for (int unsigned j = 0; j < P; j++) begin
            if (lane_spk[j]) begin
                beat_sum = beat_sum + {{(AW-W){lane_w[j][W-1]}}, lane_w[j]};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        spk_d   = spk_q;
        wts_d   = wts_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        cur_d   = cur_q;
        sat_d   = sat_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    spk_d   = input_spikes;
                    wts_d   = weights;
                    acc_d   = '0;
                    beat_d  = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_d  = acc_q + beat_sum;
                beat_d = beat_q + 1'b1;
                if (beat_q == BCW'(B - 1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                cur_d   = fin_cur;
                sat_d   = fin_sat;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            spk_q   <= '0;
            wts_q   <= '0;
            acc_q   <= '0;
            beat_q  <= '0;
            cur_q   <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            spk_q   <= spk_d;
            wts_q   <= wts_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            cur_q   <= cur_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign input_current = cur_q;
    assign saturated     = sat_q;

endmodule

// File: tb/tb_synaptic_current_accumulator.sv
// Self-checking bench: default configuration plus a small M=10/SHIFT=1 instance,
// compared against an arithmetic reference sum/shift/clamp model.
module tb_synaptic_current_accumulator;

    localparam int M  = 24;
    localparam int W  = 8;
    localparam int OW = 8;
    localparam int M2 = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic            start = 1'b0;
    logic [M-1:0]    spikes = '0;
    logic [M*W-1:0]  wts = '0;
    logic            busy, done, sat;
    logic [OW-1:0]   cur;

    logic            start2 = 1'b0;
    logic [M2-1:0]   spikes2 = '0;
    logic [M2*W-1:0] wts2 = '0;
    logic            busy2, done2, sat2;
    logic [OW-1:0]   cur2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    synaptic_current_accumulator #(.M(M), .W(W), .P(4), .OW(OW), .SHIFT(0)) dut (
        .clk(clk), .reset(reset), .start(start), .input_spikes(spikes), .weights(wts),
        .busy(busy), .done(done), .input_current(cur), .saturated(sat)
    );

    synaptic_current_accumulator #(.M(M2), .W(W), .P(4), .OW(OW), .SHIFT(1)) dut_s (
        .clk(clk), .reset(reset), .start(start2), .input_spikes(spikes2), .weights(wts2),
        .busy(busy2), .done(done2), .input_current(cur2), .saturated(sat2)
    );

    // Reference: signed dot product of spikes and weights, floor shift, clamp to 8 bits.
    function automatic void model(input logic [31:0] s, input logic [255:0] w, input int m,
                                  input int shift, output logic [7:0] res, output logic sat_o);
        int sum;
        int v;
        logic [7:0] wb;
        sum = 0;
        for (int i = 0; i < m; i++) begin
            wb = w[i*8 +: 8];
            if (s[i]) sum += int'($signed(wb));
        end
        v = sum >>> shift;
        sat_o = 1'b0;
        if (v > 127) begin v = 127; sat_o = 1'b1; end
        else if (v < -128) begin v = -128; sat_o = 1'b1; end
        res = v[7:0];
    endfunction

    function automatic logic [M*W-1:0] fill_w(input logic [7:0] v);
        logic [M*W-1:0] r;
        for (int i = 0; i < M; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    task automatic launch(input logic [M-1:0] s, input logic [M*W-1:0] w);
        @(negedge clk);
        spikes = s; wts = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
        end
    endtask

    task automatic run_and_check(input string name, input logic [M-1:0] s, input logic [M*W-1:0] w);
        logic [7:0] er;
        logic es;
        int lat;
        model(32'(s), 256'(w), M, 0, er, es);
        launch(s, w);
        wait_done(lat);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL %s latency: got %0d want 7", name, lat); end
        checks++;
        if (cur !== er) begin errors++; $display("FAIL %s current: got %0d want %0d", name, $signed(cur), $signed(er)); end
        checks++;
        if (sat !== es) begin errors++; $display("FAIL %s saturated: got %b want %b", name, sat, es); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s done_pulse: done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({busy, done, sat, cur} !== '0) begin
            errors++; $display("FAIL reset_state: busy=%b done=%b sat=%b cur=%h want zeros", busy, done, sat, cur);
        end
        checks++;
        if ({busy2, done2, sat2, cur2} !== '0) begin
            errors++; $display("FAIL reset_state_small: busy=%b done=%b sat=%b cur=%h want zeros", busy2, done2, sat2, cur2);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_saturation;
        run_and_check("all_pos", '1, fill_w(8'd10));
        run_and_check("all_neg", '1, fill_w(8'hF6));
    endtask

    task automatic test_mixed;
        logic [M*W-1:0] w;
        w = fill_w(8'd99);
        w[0 +: 8] = 8'd50;
        w[16 +: 8] = 8'hEC;
        run_and_check("mixed", 24'h000005, w);
        checks++;
        if (cur !== 8'd30 || sat !== 1'b0) begin
            errors++; $display("FAIL mixed_fixed: got %0d/%b want 30/0", $signed(cur), sat);
        end
    endtask

    task automatic test_bounds;
        logic [M*W-1:0] w;
        run_and_check("no_spikes", '0, fill_w(8'd77));
        w = fill_w(8'd0);
        w[0 +: 8] = 8'd100; w[8 +: 8] = 8'd27;
        run_and_check("upper_bound", 24'h000003, w);
        w[0 +: 8] = 8'h9C; w[8 +: 8] = 8'hE4;
        run_and_check("lower_bound", 24'h000003, w);
        w[0 +: 8] = 8'd100; w[8 +: 8] = 8'd28;
        run_and_check("above_upper", 24'h000003, w);
    endtask

    task automatic test_random;
        logic [M*W-1:0] w;
        logic [M-1:0] s;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < M; i++) w[i*8 +: 8] = 8'($urandom_range(0, 255));
            s = M'($urandom);
            if (n % 3 == 0) s = s & M'($urandom);
            run_and_check("random", s, w);
        end
    endtask

    task automatic test_back_to_back;
        logic [M*W-1:0] w;
        logic [7:0] er;
        logic es;
        int lat;
        int extra;
        for (int i = 0; i < M; i++) w[i*8 +: 8] = 8'($urandom_range(0, 40));
        model(32'h00FF00F0, 256'(w), M, 0, er, es);
        launch(24'hFF00F0, w);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c <= 4) begin
                spikes = ~spikes; wts = ~wts; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL busy_ignore latency: got %0d want 7", lat); end
        checks++;
        if (cur !== er || sat !== es) begin
            errors++; $display("FAIL busy_ignore result: got %0d/%b want %0d/%b", $signed(cur), sat, $signed(er), es);
        end
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL busy_ignore extra_activity: got %0d cycles want 0", extra); end
    endtask

    task automatic test_reset_abort;
        int seen;
        logic [M*W-1:0] w;
        launch('1, fill_w(8'd5));
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, sat, cur} !== '0) begin
            errors++; $display("FAIL abort_outputs: busy=%b done=%b sat=%b cur=%h want zeros", busy, done, sat, cur);
        end
        seen = 0;
        repeat (2) begin @(posedge clk); #1; if (done) seen++; end
        @(negedge clk); reset = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (done || busy) seen++; end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen); end
        w = fill_w(8'd99);
        w[0 +: 8] = 8'd50;
        w[16 +: 8] = 8'hEC;
        run_and_check("after_abort", 24'h000005, w);
    endtask

    task automatic test_small_config;
        logic [M2*W-1:0] w;
        logic [7:0] er;
        logic es;
        int lat;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < M2; i++) w[i*8 +: 8] = 8'd7;
            if (n == 0) spikes2 = '1;
            else if (n == 1) begin spikes2 = 10'h001; w[0 +: 8] = 8'hF9; end
            else begin
                for (int i = 0; i < M2; i++) w[i*8 +: 8] = 8'($urandom_range(0, 255));
                spikes2 = M2'($urandom);
            end
            model(32'(spikes2), 256'(w), M2, 1, er, es);
            @(negedge clk); wts2 = w; start2 = 1'b1;
            @(negedge clk); start2 = 1'b0;
            lat = -1;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk); #1;
                if (done2) begin lat = c; break; end
            end
            checks++;
            if (lat !== 4) begin errors++; $display("FAIL small latency: got %0d want 4", lat); end
            checks++;
            if (cur2 !== er || sat2 !== es) begin
                errors++; $display("FAIL small result: got %0d/%b want %0d/%b", $signed(cur2), sat2, $signed(er), es);
            end
            if (n == 0) begin
                checks++;
                if (cur2 !== 8'd35) begin errors++; $display("FAIL small_fixed: got %0d want 35", $signed(cur2)); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_saturation;
        test_mixed;
        test_bounds;
        test_random;
        test_back_to_back;
        test_reset_abort;
        test_small_config;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
